// File: rtl/data_mem_responder.sv
// Data-port memory responder: load/store over req/ready with WAIT_CYCLES wait states.
// Sub-word accesses follow RISC-V funct3 semantics; bad accesses return err=1.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic        busy,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept, go_resp;

  logic        lat_we;
  logic [31:0] lat_addr, lat_wdata;
  logic [2:0]  lat_f3;

  logic [31:0] mem [DEPTH_WORDS];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    go_resp   = 1'b0;
    case (state)
      IDLE: if (req) begin
        accept  = 1'b1;
        cnt_nxt = 4'(WAIT_CYCLES);
        if (WAIT_CYCLES == 0) begin
          state_nxt = RESP;
          go_resp   = 1'b1;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = RESP;
          go_resp   = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states the commit edge is the accept edge, so decode the live inputs then.
  logic        cur_we;
  logic [31:0] cur_addr, cur_wdata;
  logic [2:0]  cur_f3;
  assign cur_we    = (state == IDLE) ? we     : lat_we;
  assign cur_addr  = (state == IDLE) ? addr   : lat_addr;
  assign cur_wdata = (state == IDLE) ? wdata  : lat_wdata;
  assign cur_f3    = (state == IDLE) ? funct3 : lat_f3;

  logic [AW-1:0] word_idx;
  logic [1:0]    lane, size;
  logic          legal_f3, aligned, in_range, ok;
  logic [31:0]   old_word, ld_data, st_data, merged;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [3:0]    be;

  assign word_idx = cur_addr[AW+1:2];
  assign lane     = cur_addr[1:0];
  assign size     = cur_f3[1:0];
  assign in_range = cur_addr < 32'(4 * DEPTH_WORDS);
  assign legal_f3 = cur_we ? (cur_f3 inside {3'b000, 3'b001, 3'b010})
                           : (cur_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign aligned  = (size == 2'b00) || (size == 2'b01 && !lane[0]) ||
                    (size == 2'b10 && lane == 2'b00);
  assign ok       = legal_f3 && aligned && in_range;

  assign old_word = mem[word_idx];
  assign byte_v   = old_word[{lane, 3'b000} +: 8];
  assign half_v   = lane[1] ? old_word[31:16] : old_word[15:0];

  always_comb begin
    ld_data = old_word;
    st_data = cur_wdata;
    be      = 4'b1111;
    case (size)
      2'b00: begin
        ld_data = cur_f3[2] ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
        st_data = {4{cur_wdata[7:0]}};
        be      = 4'b0001 << lane;
      end
      2'b01: begin
        ld_data = cur_f3[2] ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
        st_data = {2{cur_wdata[15:0]}};
        be      = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    merged = old_word;
    for (int i = 0; i < 4; i++)
      if (be[i]) merged[8*i +: 8] = st_data[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (go_resp && ok && cur_we) mem[word_idx] <= merged;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      busy      <= 1'b0;
      ready     <= 1'b0;
      err       <= 1'b0;
      rdata     <= 32'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_f3    <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ready <= go_resp;
      if (accept) begin
        busy      <= 1'b1;
        lat_we    <= we;
        lat_addr  <= addr;
        lat_wdata <= wdata;
        lat_f3    <= funct3;
      end else if (state == RESP) begin
        busy <= 1'b0;
      end
      if (go_resp) begin
        err   <= !ok;
        rdata <= (ok && !cur_we) ? ld_data : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: instance a uses two wait states, instance b zero wait states.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_a = 0, we_a = 0, busy_a, ready_a, err_a;
  logic [31:0] addr_a = 0, wdata_a = 0, rdata_a;
  logic [2:0]  f3_a = 0;
  logic        req_b = 0, we_b = 0, busy_b, ready_b, err_b;
  logic [31:0] addr_b = 0, wdata_b = 0, rdata_b;
  logic [2:0]  f3_b = 0;

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
    .funct3(f3_a), .busy(busy_a), .ready(ready_a), .rdata(rdata_a), .err(err_a));

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
    .funct3(f3_b), .busy(busy_b), .ready(ready_b), .rdata(rdata_b), .err(err_b));

  int errors = 0;
  int checks = 0;
  logic [32:0] qa[$];
  logic [32:0] qb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: every ready pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && ready_a === 1'b1) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_ready: got ready=1 expected no response");
      end else begin
        logic [32:0] e;
        e = qa.pop_front();
        check("a_rdata", rdata_a, e[31:0]);
        check("a_err", {31'd0, err_a}, {31'd0, e[32]});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ready_b === 1'b1) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_ready: got ready=1 expected no response");
      end else begin
        logic [32:0] e;
        e = qb.pop_front();
        check("b_rdata", rdata_b, e[31:0]);
        check("b_err", {31'd0, err_b}, {31'd0, e[32]});
      end
    end
  end

  task automatic op_a(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] f3, input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    @(negedge clk);
    while (busy_a) @(negedge clk);
    req_a = 1; we_a = w; addr_a = a; wdata_a = d; f3_a = f3;
    qa.push_back({exp_err, exp_rd});
    @(posedge clk);
    #1 req_a = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("a_busy_after_accept", {31'd0, busy_a}, 32'd1);
    end while (ready_a !== 1'b1 && lat < 40);
    check("a_latency", lat, 32'd3);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_ready", {31'd0, ready_a}, 32'd0);
    check("rst_err", {31'd0, err_a}, 32'd0);
    check("rst_rdata", rdata_a, 32'd0);
    check("rst_b_busy", {31'd0, busy_b}, 32'd0);
    rst = 0;

    // Reset one cycle after accept must abort the store.
    op_a(1, 32'h08, 32'h12345678, 3'b010, 32'd0, 0);
    @(negedge clk);
    while (busy_a) @(negedge clk);
    req_a = 1; we_a = 1; addr_a = 32'h08; wdata_a = 32'hDEADBEEF; f3_a = 3'b010;
    @(posedge clk);
    #1 req_a = 0;
    @(posedge clk);
    #1 rst = 1;
    #1 check("abort_busy", {31'd0, busy_a}, 32'd0);
    check("abort_ready", {31'd0, ready_a}, 32'd0);
    @(negedge clk);
    rst = 0;
    repeat (6) @(negedge clk);
    op_a(0, 32'h08, 0, 3'b010, 32'h12345678, 0);

    op_a(1, 32'h10, 32'h8070F1A2, 3'b010, 32'd0, 0);
    op_a(0, 32'h10, 0, 3'b010, 32'h8070F1A2, 0);
    op_a(0, 32'h11, 0, 3'b000, 32'hFFFFFFF1, 0);
    op_a(0, 32'h11, 0, 3'b100, 32'h000000F1, 0);
    op_a(0, 32'h12, 0, 3'b001, 32'hFFFF8070, 0);
    op_a(0, 32'h12, 0, 3'b101, 32'h00008070, 0);

    op_a(1, 32'h20, 32'h11223344, 3'b010, 32'd0, 0);
    op_a(1, 32'h22, 32'h000000AA, 3'b000, 32'd0, 0);
    op_a(1, 32'h20, 32'h0000BEEF, 3'b001, 32'd0, 0);
    op_a(0, 32'h20, 0, 3'b010, 32'h11AABEEF, 0);

    op_a(0, 32'h22, 0, 3'b010, 32'd0, 1);
    op_a(1, 32'h21, 32'h0000FFFF, 3'b001, 32'd0, 1);
    op_a(0, 32'h20, 0, 3'b010, 32'h11AABEEF, 0);
    op_a(0, 32'h20, 0, 3'b011, 32'd0, 1);
    op_a(1, 32'h20, 32'h0, 3'b100, 32'd0, 1);
    op_a(0, 32'h100, 0, 3'b010, 32'd0, 1);
    op_a(0, 32'h20, 0, 3'b010, 32'h11AABEEF, 0);

    op_a(1, 32'hFC, 32'hCAFEF00D, 3'b010, 32'd0, 0);
    op_a(0, 32'hFC, 0, 3'b010, 32'hCAFEF00D, 0);
    op_a(0, 32'hFF, 0, 3'b000, 32'hFFFFFFCA, 0);
    op_a(0, 32'hFE, 0, 3'b101, 32'h0000CAFE, 0);

    // Zero-wait instance: seed the word, then hold req for six cycles.
    @(negedge clk);
    req_b = 1; we_b = 1; addr_b = 32'h10; wdata_b = 32'h8070F1A2; f3_b = 3'b010;
    qb.push_back({1'b0, 32'd0});
    @(posedge clk);
    #1 req_b = 0;
    repeat (3) @(negedge clk);
    req_b = 1; we_b = 0; addr_b = 32'h10; f3_b = 3'b010;
    repeat (3) qb.push_back({1'b0, 32'h8070F1A2});
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("b_busy_pattern", {31'd0, busy_b}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("b_ready_pattern", {31'd0, ready_b}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    req_b = 0;
    repeat (4) @(negedge clk);
    check("a_queue_drained", qa.size(), 32'd0);
    check("b_queue_drained", qb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
